// File: rtl/tx_arb_pkg.sv
// ---------------------------------------------------------------------------
// tx_arb_pkg
// Shared definitions for the transmit command arbiter: FSM state encoding,
// default requester count, default watchdog limit and a small pointer helper.
// Imported by rr_pick and tx_cmd_arbiter.
// ---------------------------------------------------------------------------
package tx_arb_pkg;

    // Number of requesters; the round-robin picker is built for exactly four.
    localparam int NREQ_DEFAULT = 4;

    // Watchdog limit: 5 s at 50 MHz.
    localparam logic [27:0] TIMEOUT_CYC_DEFAULT = 28'd250000000;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_ACCEPT = 2'd2,
        WAIT_DONE   = 2'd3
    } arb_state_e;

    // Next round-robin start position after serving requester idx (2-bit wrap).
    function automatic logic [1:0] nextPtr(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/tx_cmd_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin priority search over four requesters.
// The search starts at rr_ptr and walks upward with wrap-around
// (rr_ptr, rr_ptr+1, ..., 3, 0, ..., rr_ptr-1); the first set bit wins.
//
// Ports:
//   req     in  [3:0]  per-requester request levels
//   rr_ptr  in  [1:0]  highest-priority position for this search
//   valid   out        at least one request is set
//   idx     out [1:0]  index of the winning requester (rr_ptr when !valid)
// ---------------------------------------------------------------------------
module rr_pick
    import tx_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] rr_ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk the offsets from farthest to nearest so the candidate closest to
    // rr_ptr is the last one written and therefore takes priority.
    always_comb begin
        valid = 1'b0;
        idx   = rr_ptr;
        cand  = rr_ptr;
        for (int off = 3; off >= 0; off--) begin
            cand = rr_ptr + 2'(off);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tx_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tx_cmd_arbiter
// Round-robin arbiter that forwards one 8-bit command at a time from four
// requesters to a message sequencer using a ready/strobe handshake.
//
// Optional feature: define ARB_TIMEOUT_EN to build a per-command watchdog.
// When the sequencer stalls for TIMEOUT_CYC cycles in WAIT_ACCEPT/WAIT_DONE
// the transaction is force-completed and the sticky timeout_err is raised.
// Without the macro no watchdog exists and timeout_err is tied low.
//
// Parameters:
//   NREQ         number of requesters (4 in this revision)
//   TIMEOUT_CYC  watchdog limit in clk cycles (must be >= 1)
//
// Ports:
//   clk          in        system clock, rising edge
//   rst          in        asynchronous active-low reset
//   req          in  [3:0] level requests, held until ack
//   cmd_flat     in [31:0] requester i command in bits [8i+7:8i]
//   ack          out [3:0] one-cycle completion pulse for the granted port
//   cmd_out      out [7:0] command presented to the sequencer
//   str_out      out       one-cycle start strobe
//   ready_in     in        sequencer idle/ready
//   grant_id     out [1:0] current or last granted requester
//   busy         out       FSM is not in IDLE
//   timeout_err  out       sticky watchdog flag
// ---------------------------------------------------------------------------
module tx_cmd_arbiter
    import tx_arb_pkg::*;
#(
    parameter int          NREQ        = NREQ_DEFAULT,
    parameter logic [27:0] TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] cmd_flat,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        cmd_out,
    output logic              str_out,
    input  logic              ready_in,
    output logic [1:0]        grant_id,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [NREQ-1:0] ACK_ONE = NREQ'(1);

    arb_state_e      state_q;
    logic [1:0]      rr_ptr_q;
    logic [1:0]      grant_q;
    logic [7:0]      cmd_q;
    logic            str_q;
    logic [NREQ-1:0] ack_q;

    logic            pickValid;
    logic [1:0]      pickIdx;

    rr_pick u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pickValid),
        .idx    (pickIdx)
    );

`ifdef ARB_TIMEOUT_EN
    logic [27:0] wdog_q;
    logic        timeout_q;
`endif

    // Main FSM. All outputs are registered. A grant is blocked while ack_q is
    // still high so a requester that has not yet dropped its level request
    // cannot be granted again on a stale req.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 2'd0;
            grant_q   <= 2'd0;
            cmd_q     <= 8'd0;
            str_q     <= 1'b0;
            ack_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            wdog_q    <= 28'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            str_q <= 1'b0;
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (ready_in && pickValid && (ack_q == '0)) begin
                        grant_q <= pickIdx;
                        cmd_q   <= cmd_flat[{pickIdx, 3'b000} +: 8];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    str_q   <= 1'b1;
                    state_q <= WAIT_ACCEPT;
                end
                WAIT_ACCEPT: begin
                    if (!ready_in) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (ready_in) begin
                        ack_q    <= ACK_ONE << grant_q;
                        rr_ptr_q <= nextPtr(grant_q);
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef ARB_TIMEOUT_EN
            // The counter runs only while waiting on the sequencer; the
            // TIMEOUT_CYC-th waiting cycle force-completes the transaction.
            if ((state_q == WAIT_ACCEPT) || (state_q == WAIT_DONE)) begin
                if (wdog_q == TIMEOUT_CYC - 28'd1) begin
                    wdog_q    <= 28'd0;
                    timeout_q <= 1'b1;
                    ack_q     <= ACK_ONE << grant_q;
                    rr_ptr_q  <= nextPtr(grant_q);
                    state_q   <= IDLE;
                end else begin
                    wdog_q <= wdog_q + 28'd1;
                end
            end else begin
                wdog_q <= 28'd0;
            end
`endif
        end
    end

    assign ack      = ack_q;
    assign cmd_out  = cmd_q;
    assign str_out  = str_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    // The limit is meaningless without the watchdog; fold it away here.
    logic unused_cfg;
    assign unused_cfg  = ^TIMEOUT_CYC;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/tx_cmd_arbiter.md
TX_CMD_ARBITER -- requirements
Module: tx_cmd_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (fixed 4 in this revision).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 28'd250000000, per-command watchdog limit in clk cycles.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz), all logic on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  4  per-requester level request; held until ack.
REQ-006 SHALL have port cmd_flat  input  32  requester i command ID in bits [8i+7:8i].
REQ-007 SHALL have port ack  output  4  one-cycle pulse, command of requester i completed.
REQ-008 SHALL have port cmd_out  output  8  command ID to the message sequencer.
REQ-009 SHALL have port str_out  output  1  one-cycle start strobe to the sequencer.
REQ-010 SHALL have port ready_in  input  1  sequencer idle/ready flag (1 = may start).
REQ-011 SHALL have port grant_id  output  2  index of current or last granted requester.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port timeout_err  output  1  sticky watchdog flag (ARB_TIMEOUT_EN only; else tied 0).

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE.
REQ-015 IDLE: if ready_in=1 and req!=0, SHALL grant the first set req bit searching from rr_ptr upward with wrap (rr_ptr..3,0..rr_ptr-1), latch grant_id and cmd_out, go ISSUE.
REQ-016 IDLE with req=0 or ready_in=0 SHALL remain IDLE; cmd_out holds last value.
REQ-017 ISSUE SHALL drive str_out=1 for exactly one cycle, then go WAIT_ACCEPT.
REQ-018 WAIT_ACCEPT SHALL wait for ready_in=0 (sequencer captured command), then go WAIT_DONE.
REQ-019 WAIT_DONE SHALL wait for ready_in=1, then pulse ack[grant_id] one cycle, set rr_ptr=grant_id+1 (mod 4, 2-bit wrap), go IDLE.
REQ-020 A requester granted SHALL not be re-granted before every other requesting port has been served once (round-robin fairness).
REQ-021 cmd_out SHALL be stable from ISSUE through WAIT_DONE; changes on cmd_flat or req after grant SHALL be ignored.
REQ-022 Deassertion of the granted req mid-transaction SHALL not abort; ack still pulses.
REQ-023 Grant decision and ack SHALL never occur in the same cycle; minimum IDLE dwell is 1 cycle between transactions.
REQ-024 Latency req->str_out SHALL be 2 cycles when IDLE and ready_in=1.

Reset
REQ-025 On rst=0 SHALL asynchronously force state=IDLE, rr_ptr=0, grant_id=0, cmd_out=0, str_out=0, ack=0, busy=0, timeout_err=0, watchdog=0.
REQ-026 Reset mid-transaction SHALL drop the grant with no ack pulse.

Configuration
REQ-027 With macro ARB_TIMEOUT_EN defined, a watchdog SHALL count cycles in WAIT_ACCEPT/WAIT_DONE; reaching TIMEOUT_CYC SHALL set timeout_err, pulse ack[grant_id], advance rr_ptr, return IDLE; timeout_err clears only on reset.
REQ-028 Without ARB_TIMEOUT_EN, no watchdog logic SHALL be generated, waits are unbounded, timeout_err=0.

Structure
REQ-029 State encodings, NREQ and default TIMEOUT_CYC SHALL live in shared package tx_arb_pkg.
REQ-030 Round-robin priority search SHALL be sub-module rr_pick (inputs req, rr_ptr; outputs valid, idx), purely combinational.

Verification
REQ-031 Single req=4'b0001, cmd 8'h03, ready_in=1 -> str_out at cycle 2, cmd_out=8'h03; model drops/raises ready_in -> ack=4'b0001 one cycle.
REQ-032 req=4'b1111 continuous, cmds 00/01/02/03 -> grant order 0,1,2,3,0; exactly one ack per transaction.
REQ-033 rr_ptr=3 after serving 2, req=4'b0101 -> grant 0 (wrap), then 2.
REQ-034 ready_in held 0 in IDLE with req=4'b0010 -> no str_out until ready_in=1.
REQ-035 ARB_TIMEOUT_EN, TIMEOUT_CYC=100, ready_in stuck 1 after str_out -> at 100 cycles timeout_err=1, ack pulses, next requester granted.
REQ-036 rst=0 asserted in WAIT_DONE -> all outputs 0 immediately, no ack; after release req=4'b0100 granted first (rr_ptr=0 search).
